// File: rtl/axi_reg_slice_pkg.sv
// axi_reg_slice_pkg: shared types, field widths and per-channel payload geometry for the AXI register slice.
package axi_reg_slice_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W = 4;
  localparam int STALL_CNT_W = 32;
  typedef enum logic { MODE_BYPASS, MODE_REG } mode_e;
  typedef enum logic [2:0] { CH_AW, CH_W, CH_B, CH_AR, CH_R } ch_e;
  typedef enum logic [1:0] { ST_EMPTY, ST_ONE, ST_FULL } stage_e;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DATA_W/8-1:0] strb_t;
  typedef logic [ID_W-1:0] id_t;
  typedef logic [1:0] burst_t;
  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] resp_t;
  typedef struct packed { addr_t addr; burst_t burst; len_t len; size_t size; id_t id; } ax_pl_t;
  typedef struct packed { data_t data; strb_t strb; logic last; } w_pl_t;
  typedef struct packed { resp_t resp; id_t id; } b_pl_t;
  typedef struct packed { data_t data; logic last; id_t id; resp_t resp; } r_pl_t;
  localparam int PL_TOTAL = 2 * $bits(ax_pl_t) + $bits(w_pl_t) + $bits(b_pl_t) + $bits(r_pl_t);
  function automatic int pl_w(ch_e c);
    return c == CH_W ? $bits(w_pl_t) : c == CH_B ? $bits(b_pl_t) : c == CH_R ? $bits(r_pl_t) : $bits(ax_pl_t);
  endfunction
  // Channels are packed into one flat vector in channel-index order, AW in the LSBs.
  function automatic int pl_off(ch_e c);
    int o = 0;
    for (int i = 0; i < int'(c); i++) o += pl_w(ch_e'(i));
    return o;
  endfunction
endpackage

// File: rtl/axi_reg_slice_if.sv
// axi_bus_t: AXI4 bus bundle (AW, W, B, AR, R); master drives requests and response readies, slave the rest.
interface axi_bus_t;
  import axi_reg_slice_pkg::*;
  addr_t awaddr;
  burst_t awburst;
  len_t awlen;
  size_t awsize;
  id_t awid;
  logic awvalid, awready;
  data_t wdata;
  strb_t wstrb;
  logic wlast, wvalid, wready;
  resp_t bresp;
  id_t bid;
  logic bvalid, bready;
  addr_t araddr;
  burst_t arburst;
  len_t arlen;
  size_t arsize;
  id_t arid;
  logic arvalid, arready;
  data_t rdata;
  logic rlast;
  id_t rid;
  resp_t rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awburst, awlen, awsize, awid, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bid, bvalid, output bready,
    output araddr, arburst, arlen, arsize, arid, arvalid, input arready,
    input rdata, rlast, rid, rresp, rvalid, output rready
  );
  modport slave (
    input awaddr, awburst, awlen, awsize, awid, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bid, bvalid, input bready,
    input araddr, arburst, arlen, arsize, arid, arvalid, output arready,
    output rdata, rlast, rid, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_reg_slice_skid_stage.sv
// axi_skid_stage: two-entry skid buffer; ready/valid decode from registered state only, so no comb path crosses it.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module axi_skid_stage import axi_reg_slice_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  stage_e state;
  logic [W-1:0] skid;
  logic push, pop;
  assign in_ready = state != ST_FULL;
  assign out_valid = state != ST_EMPTY;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_EMPTY;
    else if (push && !pop) state <= state == ST_EMPTY ? ST_ONE : ST_FULL;
    else if (pop && !push) state <= state == ST_FULL ? ST_ONE : ST_EMPTY;
  // out_data always holds the oldest beat; skid only holds the younger one while FULL.
  always_ff @(posedge clk) begin
    if (push && (state == ST_EMPTY || pop)) out_data <= in_data;
    else if (pop && state == ST_FULL) out_data <= skid;
    if (push && !pop && state == ST_ONE) skid <= in_data;
  end
endmodule

// File: rtl/axi_reg_slice.sv
// axi_reg_slice: AXI4 register slice, each channel either bypass wires or a chain of PIPE_LEVEL skid stages.
// Ports: clk, rst_n (async active-low), s_axi (upstream slave), m_axi (downstream master);
// with AXI_REG_SLICE_STATS_EN also stats_clr and stall_cnt (per-channel stall counters, index AW,W,B,AR,R).
module axi_reg_slice import axi_reg_slice_pkg::*; #(
  parameter int    PIPE_LEVEL = 3,
  parameter mode_e AW_MODE    = MODE_REG,
  parameter mode_e W_MODE     = MODE_REG,
  parameter mode_e B_MODE     = MODE_REG,
  parameter mode_e AR_MODE    = MODE_REG,
  parameter mode_e R_MODE     = MODE_REG
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AXI_REG_SLICE_STATS_EN
  input  logic stats_clr,
  output logic [4:0][STALL_CNT_W-1:0] stall_cnt,
`endif
  axi_bus_t.slave  s_axi,
  axi_bus_t.master m_axi
);
  localparam logic [4:0] REG_CH = {R_MODE == MODE_REG, AR_MODE == MODE_REG, B_MODE == MODE_REG,
                                   W_MODE == MODE_REG, AW_MODE == MODE_REG};
  ax_pl_t aw_i, aw_o, ar_i, ar_o;
  w_pl_t w_i, w_o;
  b_pl_t b_i, b_o;
  r_pl_t r_i, r_o;
  logic [PL_TOTAL-1:0] in_pl, out_pl;
  logic [4:0] in_valid, in_ready, out_valid, out_ready;
  assign aw_i = {s_axi.awaddr, s_axi.awburst, s_axi.awlen, s_axi.awsize, s_axi.awid};
  assign w_i = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign b_i = {m_axi.bresp, m_axi.bid};
  assign ar_i = {s_axi.araddr, s_axi.arburst, s_axi.arlen, s_axi.arsize, s_axi.arid};
  assign r_i = {m_axi.rdata, m_axi.rlast, m_axi.rid, m_axi.rresp};
  assign {m_axi.awaddr, m_axi.awburst, m_axi.awlen, m_axi.awsize, m_axi.awid} = aw_o;
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_o;
  assign {s_axi.bresp, s_axi.bid} = b_o;
  assign {m_axi.araddr, m_axi.arburst, m_axi.arlen, m_axi.arsize, m_axi.arid} = ar_o;
  assign {s_axi.rdata, s_axi.rlast, s_axi.rid, s_axi.rresp} = r_o;
  assign in_pl = {r_i, ar_i, b_i, w_i, aw_i};
  assign {r_o, ar_o, b_o, w_o, aw_o} = out_pl;
  // "in" is the producing side of each channel: s_axi for AW/W/AR, m_axi for B/R.
  assign in_valid = {m_axi.rvalid, s_axi.arvalid, m_axi.bvalid, s_axi.wvalid, s_axi.awvalid};
  assign out_ready = {s_axi.rready, m_axi.arready, s_axi.bready, m_axi.wready, m_axi.awready};
  assign {s_axi.rvalid, m_axi.arvalid, s_axi.bvalid, m_axi.wvalid, m_axi.awvalid} = out_valid;
  assign {m_axi.rready, s_axi.arready, m_axi.bready, s_axi.wready, s_axi.awready} = in_ready;
  for (genvar c = 0; c < 5; c++) begin : g_ch
    localparam int W = pl_w(ch_e'(c));
    localparam int O = pl_off(ch_e'(c));
    if (!REG_CH[c]) begin : g_byp
      assign out_pl[O +: W] = in_pl[O +: W];
      assign out_valid[c] = in_valid[c];
      assign in_ready[c] = out_ready[c];
    end else begin : g_reg
      logic [W-1:0] d [PIPE_LEVEL+1];
      logic [PIPE_LEVEL:0] v, r;
      assign d[0] = in_pl[O +: W];
      assign v[0] = in_valid[c];
      assign in_ready[c] = r[0];
      assign out_pl[O +: W] = d[PIPE_LEVEL];
      assign out_valid[c] = v[PIPE_LEVEL];
      assign r[PIPE_LEVEL] = out_ready[c];
      for (genvar s = 0; s < PIPE_LEVEL; s++) begin : g_st
        axi_skid_stage #(.W(W)) u_stage (
          .clk, .rst_n,
          .in_valid(v[s]), .in_ready(r[s]), .in_data(d[s]),
          .out_valid(v[s+1]), .out_ready(r[s+1]), .out_data(d[s+1])
        );
      end
    end
  end
`ifdef AXI_REG_SLICE_STATS_EN
  // A stall is a downstream-side beat offered but not taken; clear beats increment, counts saturate.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else for (int i = 0; i < 5; i++)
      stall_cnt[i] <= stats_clr ? '0 :
                      (out_valid[i] && !out_ready[i] && stall_cnt[i] != '1) ? stall_cnt[i] + STALL_CNT_W'(1) :
                      stall_cnt[i];
`endif
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: directed + random checks of axi_reg_slice against a per-channel FIFO reference model.
module tb_axi_reg_slice;
  import axi_reg_slice_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_bus_t s_bus();
  axi_bus_t m_bus();
  axi_bus_t s2_bus();
  axi_bus_t m2_bus();
`ifdef AXI_REG_SLICE_STATS_EN
  logic stats_clr = 1'b0;
  logic [4:0][STALL_CNT_W-1:0] stall_cnt, stall_cnt2;
`endif
  axi_reg_slice dut (
    .clk, .rst_n,
`ifdef AXI_REG_SLICE_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(stall_cnt),
`endif
    .s_axi(s_bus), .m_axi(m_bus)
  );
  axi_reg_slice #(.R_MODE(MODE_BYPASS)) dut2 (
    .clk, .rst_n,
`ifdef AXI_REG_SLICE_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(stall_cnt2),
`endif
    .s_axi(s2_bus), .m_axi(m2_bus)
  );
  int nchk = 0, nfail = 0;
  logic [63:0] up_p [5];
  logic [63:0] prev_pl [5];
  logic [63:0] mq [5][64];
  int wr [5], rd [5], rxn [5];
  logic [4:0] up_v, dn_r, hs_up_f, hs_dn_f, up_rdy_f, dn_vld_f, prev_stall;
  int k, base, r0;
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] dn_vld_vec();
    return {s_bus.rvalid, m_bus.arvalid, s_bus.bvalid, m_bus.wvalid, m_bus.awvalid};
  endfunction
  function automatic logic [4:0] up_rdy_vec();
    return {m_bus.rready, s_bus.arready, m_bus.bready, s_bus.wready, s_bus.awready};
  endfunction
  function automatic logic [63:0] up_pl(int c);
    case (c)
      0: return 64'({s_bus.awaddr, s_bus.awburst, s_bus.awlen, s_bus.awsize, s_bus.awid});
      1: return 64'({s_bus.wdata, s_bus.wstrb, s_bus.wlast});
      2: return 64'({m_bus.bresp, m_bus.bid});
      3: return 64'({s_bus.araddr, s_bus.arburst, s_bus.arlen, s_bus.arsize, s_bus.arid});
      default: return 64'({m_bus.rdata, m_bus.rlast, m_bus.rid, m_bus.rresp});
    endcase
  endfunction
  function automatic logic [63:0] dn_pl(int c);
    case (c)
      0: return 64'({m_bus.awaddr, m_bus.awburst, m_bus.awlen, m_bus.awsize, m_bus.awid});
      1: return 64'({m_bus.wdata, m_bus.wstrb, m_bus.wlast});
      2: return 64'({s_bus.bresp, s_bus.bid});
      3: return 64'({m_bus.araddr, m_bus.arburst, m_bus.arlen, m_bus.arsize, m_bus.arid});
      default: return 64'({s_bus.rdata, s_bus.rlast, s_bus.rid, s_bus.rresp});
    endcase
  endfunction
  task automatic drive();
    s_bus.awvalid = up_v[0];
    {s_bus.awaddr, s_bus.awburst, s_bus.awlen, s_bus.awsize, s_bus.awid} = up_p[0][48:0];
    s_bus.wvalid = up_v[1];
    {s_bus.wdata, s_bus.wstrb, s_bus.wlast} = up_p[1][36:0];
    m_bus.bvalid = up_v[2];
    {m_bus.bresp, m_bus.bid} = up_p[2][5:0];
    s_bus.arvalid = up_v[3];
    {s_bus.araddr, s_bus.arburst, s_bus.arlen, s_bus.arsize, s_bus.arid} = up_p[3][48:0];
    m_bus.rvalid = up_v[4];
    {m_bus.rdata, m_bus.rlast, m_bus.rid, m_bus.rresp} = up_p[4][38:0];
    m_bus.awready = dn_r[0];
    m_bus.wready = dn_r[1];
    s_bus.bready = dn_r[2];
    m_bus.arready = dn_r[3];
    s_bus.rready = dn_r[4];
  endtask
  // One clock: drive, sample at negedge, update the FIFO model, return just after the next posedge.
  task automatic cycle();
    logic [4:0] upv, dnv;
    drive();
    @(negedge clk);
    upv = up_rdy_vec();
    dnv = dn_vld_vec();
    up_rdy_f = upv;
    dn_vld_f = dnv;
    hs_up_f = up_v & upv;
    hs_dn_f = dnv & dn_r;
    for (int c = 0; c < 5; c++) begin
      if (hs_up_f[c]) begin
        mq[c][wr[c] % 64] = up_pl(c);
        wr[c]++;
        check($sformatf("occupancy[%0d]", c), 64'(wr[c] - rd[c] <= 6), 64'd1);
      end
      if (prev_stall[c]) begin
        check($sformatf("stall_valid[%0d]", c), 64'(dnv[c]), 64'd1);
        check($sformatf("stall_payload[%0d]", c), dn_pl(c), prev_pl[c]);
      end
      if (hs_dn_f[c]) begin
        check($sformatf("beat_expected[%0d]", c), 64'(wr[c] > rd[c]), 64'd1);
        check($sformatf("beat_payload[%0d]", c), dn_pl(c), mq[c][rd[c] % 64]);
        rd[c]++;
        rxn[c]++;
      end
      prev_stall[c] = dnv[c] & ~dn_r[c];
      prev_pl[c] = dn_pl(c);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    up_v = '0;
    dn_r = '0;
    prev_stall = '0;
    hs_up_f = '0;
    for (int c = 0; c < 5; c++) begin
      up_p[c] = '0;
      wr[c] = 0;
      rd[c] = 0;
      rxn[c] = 0;
    end
    drive();
    {s2_bus.awaddr, s2_bus.awburst, s2_bus.awlen, s2_bus.awsize, s2_bus.awid, s2_bus.awvalid} = '0;
    {s2_bus.wdata, s2_bus.wstrb, s2_bus.wlast, s2_bus.wvalid, s2_bus.bready, s2_bus.rready} = '0;
    {s2_bus.araddr, s2_bus.arburst, s2_bus.arlen, s2_bus.arsize, s2_bus.arid, s2_bus.arvalid} = '0;
    {m2_bus.awready, m2_bus.wready, m2_bus.arready, m2_bus.bresp, m2_bus.bid, m2_bus.bvalid} = '0;
    {m2_bus.rdata, m2_bus.rlast, m2_bus.rid, m2_bus.rresp, m2_bus.rvalid} = '0;
    #3;
    check("reset_valids", 64'(dn_vld_vec()), 64'h0);
    check("reset_readies", 64'(up_rdy_vec()), 64'h1f);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // 16 back-to-back AW beats with every ready high: first arrives 3 cycles later, one per cycle.
    dn_r = '1;
    for (int i = 0; i < 20; i++) begin
      up_v[0] = i < 16;
      up_p[0] = {$urandom, $urandom};
      cycle();
      check("aw_ready_held", 64'(up_rdy_f[0]), 64'd1);
      check("aw_latency", 64'(hs_dn_f[0]), 64'(i >= 3 && i < 19));
    end
    check("aw_count", 64'(rxn[0]), 64'd16);
    // W backpressure: exactly 6 beats fit, then everything drains in order.
    dn_r[1] = 1'b0;
    base = rxn[1];
    k = 0;
    for (int i = 0; i < 12; i++) begin
      up_v[1] = k < 8;
      up_p[1] = {$urandom, $urandom};
      cycle();
      if (hs_up_f[1]) k++;
    end
    check("w_accepted", 64'(k), 64'd6);
    check("w_ready_low", 64'(up_rdy_f[1]), 64'd0);
    dn_r[1] = 1'b1;
    for (int i = 0; i < 30 && rxn[1] - base < 8; i++) begin
      if (hs_up_f[1]) begin
        k++;
        up_p[1] = {$urandom, $urandom};
      end
      up_v[1] = k < 8;
      cycle();
    end
    check("w_drained", 64'(rxn[1] - base), 64'd8);
    // Random valid/ready on all five channels.
    up_v = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 5; c++) begin
        if (!up_v[c] || hs_up_f[c]) begin
          up_v[c] = 1'($urandom_range(0, 1));
          up_p[c] = {$urandom, $urandom};
        end
        dn_r[c] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    up_v = '0;
    dn_r = '1;
    repeat (20) cycle();
    for (int c = 0; c < 5; c++) check($sformatf("no_loss[%0d]", c), 64'(wr[c] - rd[c]), 64'd0);
    // Asynchronous reset with 4 AW beats buffered.
    dn_r[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_v[0] = 1'b1;
      up_p[0] = {$urandom, $urandom};
      cycle();
    end
    up_v = '0;
    drive();
    check("pre_reset_awvalid", 64'(m_bus.awvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valids", 64'(dn_vld_vec()), 64'h0);
    check("async_reset_readies", 64'(up_rdy_vec()), 64'h1f);
    m2_bus.rvalid = 1'b1;
    m2_bus.rdata = 32'h3c;
    #1;
    check("bypass_in_reset", 64'(s2_bus.rvalid), 64'd1);
    for (int c = 0; c < 5; c++) rd[c] = wr[c];
    prev_stall = '0;
    r0 = rxn[0];
    @(posedge clk);
    #1 rst_n = 1'b1;
    m2_bus.rvalid = 1'b0;
    dn_r = '1;
    repeat (10) cycle();
    check("no_stale_beat", 64'(rxn[0]), 64'(r0));
    // R bypass on dut2 is combinational; AR on dut2 keeps three cycles of latency.
    m2_bus.rvalid = 1'b1;
    m2_bus.rdata = 32'ha5;
    s2_bus.rready = 1'b1;
    #1;
    check("bypass_rvalid", 64'(s2_bus.rvalid), 64'd1);
    check("bypass_rdata", 64'(s2_bus.rdata), 64'ha5);
    check("bypass_rready", 64'(m2_bus.rready), 64'd1);
    m2_bus.rdata = 32'h5a;
    #1;
    check("bypass_rdata2", 64'(s2_bus.rdata), 64'h5a);
    m2_bus.rvalid = 1'b0;
    @(posedge clk);
    #1;
    m2_bus.arready = 1'b1;
    s2_bus.arvalid = 1'b1;
    s2_bus.araddr = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("byp_ar_latency", 64'(m2_bus.arvalid), 64'(i == 3));
      if (i == 3) check("byp_araddr", 64'(m2_bus.araddr), 64'h1234_5678);
      @(posedge clk);
      #1;
      s2_bus.arvalid = 1'b0;
    end
`ifdef AXI_REG_SLICE_STATS_EN
    // AR beat waits with arready low: ten stalled cycles give a count of ten.
    dn_r = 5'b10111;
    up_v[3] = 1'b1;
    up_p[3] = {$urandom, $urandom};
    cycle();
    up_v[3] = 1'b0;
    for (int i = 0; i < 10 && !dn_vld_f[3]; i++) cycle();
    check("ar_waiting", 64'(dn_vld_f[3]), 64'd1);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    repeat (10) cycle();
    check("stall_ar", 64'(stall_cnt[CH_AR]), 64'd10);
    check("stall_aw", 64'(stall_cnt[CH_AW]), 64'd0);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    check("stall_clr", 64'(stall_cnt[CH_AR]), 64'd0);
    dn_r = '1;
    repeat (5) cycle();
`endif
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
